// File: rtl/eth_hdr_pkg.sv
// Shared constants, state encoding and byte-lane helper for the 64-bit
// Ethernet header receive path.
package eth_hdr_pkg;

    localparam int ETH_HDR_LEN   = 14;
    localparam int LANES         = 8;
    localparam int DEST_OFF      = 0;
    localparam int SRC_OFF       = 6;
    localparam int TYPE_OFF      = 12;
    localparam int REALIGN_LANES = 6;

    // Header bytes carried by the second word; the rest of that word is payload.
    localparam int HDR1_LANES = ETH_HDR_LEN - LANES;
    localparam logic [LANES-1:0] HDR1_KEEP = LANES'((1 << HDR1_LANES) - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_PAYLOAD,
        ST_FLUSH,
        ST_DROP
    } eth_rx_state_t;

    function automatic logic [7:0] lane_byte(input logic [63:0] d, input int lane);
        return d[lane*8 +: 8];
    endfunction

endpackage

// File: rtl/eth_rx_realign_64.sv
// Residual holder and lane shifter: moves payload down by REALIGN_LANES so the
// byte after the header lands in lane 0, and builds the matching tkeep.
module eth_rx_realign_64
    import eth_hdr_pkg::*;
#(
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [63:0]           in_data,
    input  logic [7:0]            in_keep,
    input  logic                  in_last,
    input  logic [USER_WIDTH-1:0] in_user,
    output logic [63:0]           pay_data,
    output logic [7:0]            pay_keep,
    output logic                  pay_last,
    output logic [63:0]           flush_data,
    output logic [7:0]            flush_keep,
    output logic [USER_WIDTH-1:0] flush_user
);

    localparam int RES_LANES = LANES - REALIGN_LANES;
    localparam int RES_W     = RES_LANES * 8;

    logic [RES_W-1:0]      res_p0;
    logic [RES_LANES-1:0]  res_keep_p0;
    logic [USER_WIDTH-1:0] res_user_p0;
    logic                  tail_empty;

    // Residual stage: the top lanes of each accepted word wait for the next beat
    always_ff @(posedge clk) begin
        if (rst) begin
            res_p0      <= '0;
            res_keep_p0 <= '0;
            res_user_p0 <= '0;
        end else if (load) begin
            res_p0      <= in_data[63 -: RES_W];
            res_keep_p0 <= in_keep[LANES-1 -: RES_LANES];
            res_user_p0 <= in_user;
        end
    end

    always_comb begin
        tail_empty = (in_keep[LANES-1 -: RES_LANES] == '0);
        pay_data   = {in_data[REALIGN_LANES*8-1:0], res_p0};
        pay_last   = in_last && tail_empty;
        pay_keep   = pay_last ? {in_keep[REALIGN_LANES-1:0], {RES_LANES{1'b1}}} : 8'hFF;
        flush_data = {{(REALIGN_LANES*8){1'b0}}, res_p0};
        flush_keep = {{REALIGN_LANES{1'b0}}, res_keep_p0};
        flush_user = res_user_p0;
    end

endmodule

// File: rtl/eth_hdr_rx_64.sv
// Ethernet header parser for a 64-bit AXI stream: splits the 14-byte header
// onto its own handshake and forwards the realigned payload.
module eth_hdr_rx_64
    import eth_hdr_pkg::*;
#(
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           s_axis_tdata,
    input  logic [7:0]            s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  m_eth_hdr_valid,
    input  logic                  m_eth_hdr_ready,
    output logic [47:0]           m_eth_dest_mac,
    output logic [47:0]           m_eth_src_mac,
    output logic [15:0]           m_eth_type,
    output logic [63:0]           m_eth_payload_axis_tdata,
    output logic [7:0]            m_eth_payload_axis_tkeep,
    output logic                  m_eth_payload_axis_tvalid,
    input  logic                  m_eth_payload_axis_tready,
    output logic                  m_eth_payload_axis_tlast,
    output logic [USER_WIDTH-1:0] m_eth_payload_axis_tuser,
    output logic                  busy,
    output logic                  error_header_early_termination
);

    eth_rx_state_t state, state_nxt;

    logic                  s_acc, out_free, hdr_ok, full_word;
    logic                  rlgn_load, pay_load, flush_load, hdr_set, err_set;
    logic [47:0]           dest_p1, src_p1;
    logic [15:0]           type_p1;
    logic                  hdr_vld_p1, err_p1;
    logic [63:0]           pay_data_p1;
    logic [7:0]            pay_keep_p1;
    logic                  pay_last_p1, vld_p1;
    logic [USER_WIDTH-1:0] pay_user_p1;

    logic [63:0]           rl_data, rl_flush_data;
    logic [7:0]            rl_keep, rl_flush_keep;
    logic                  rl_last;
    logic [USER_WIDTH-1:0] rl_flush_user;

    eth_rx_realign_64 #(.USER_WIDTH(USER_WIDTH)) u_realign (
        .clk        (clk),
        .rst        (rst),
        .load       (rlgn_load),
        .in_data    (s_axis_tdata),
        .in_keep    (s_axis_tkeep),
        .in_last    (s_axis_tlast),
        .in_user    (s_axis_tuser),
        .pay_data   (rl_data),
        .pay_keep   (rl_keep),
        .pay_last   (rl_last),
        .flush_data (rl_flush_data),
        .flush_keep (rl_flush_keep),
        .flush_user (rl_flush_user)
    );

    assign s_acc     = s_axis_tvalid && s_axis_tready;
    assign out_free  = !vld_p1 || m_eth_payload_axis_tready;
    assign hdr_ok    = (s_axis_tkeep & HDR1_KEEP) == HDR1_KEEP;
    assign full_word = (s_axis_tkeep == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (s_acc) begin
                if (s_axis_tlast)    state_nxt = ST_IDLE;
                else if (!full_word) state_nxt = ST_DROP;
                else                 state_nxt = ST_HDR1;
            end
            // A 14-byte frame also goes through FLUSH, which then emits an empty last beat
            ST_HDR1: if (s_acc) begin
                if (s_axis_tlast)    state_nxt = hdr_ok ? ST_FLUSH : ST_IDLE;
                else if (!full_word) state_nxt = ST_DROP;
                else                 state_nxt = ST_PAYLOAD;
            end
            ST_PAYLOAD: if (s_acc && s_axis_tlast) begin
                state_nxt = rl_last ? ST_IDLE : ST_FLUSH;
            end
            ST_FLUSH: if (out_free) state_nxt = ST_IDLE;
            ST_DROP:  if (s_acc && s_axis_tlast) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = 1'b0;
        hdr_set       = 1'b0;
        err_set       = 1'b0;
        rlgn_load     = 1'b0;
        pay_load      = 1'b0;
        flush_load    = 1'b0;
        case (state)
            ST_IDLE: begin
                s_axis_tready = !hdr_vld_p1 && !rst;
                err_set       = s_acc && s_axis_tlast;
            end
            ST_HDR1: begin
                s_axis_tready = !hdr_vld_p1 && !rst;
                rlgn_load     = s_acc;
                hdr_set       = s_acc && (s_axis_tlast ? hdr_ok : full_word);
                err_set       = s_acc && s_axis_tlast && !hdr_ok;
            end
            ST_PAYLOAD: begin
                s_axis_tready = out_free && !rst;
                rlgn_load     = s_acc;
                pay_load      = s_acc;
            end
            ST_FLUSH: flush_load = out_free;
            ST_DROP:  s_axis_tready = !rst;
            default:  s_axis_tready = 1'b0;
        endcase
    end

    // Header and payload output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            dest_p1     <= '0;
            src_p1      <= '0;
            type_p1     <= '0;
            hdr_vld_p1  <= 1'b0;
            err_p1      <= 1'b0;
            pay_data_p1 <= '0;
            pay_keep_p1 <= '0;
            pay_last_p1 <= 1'b0;
            pay_user_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            err_p1 <= err_set;
            if (hdr_vld_p1 && m_eth_hdr_ready) hdr_vld_p1 <= 1'b0;
            if (hdr_set) hdr_vld_p1 <= 1'b1;
            if (s_acc && state == ST_IDLE) begin
                dest_p1 <= {lane_byte(s_axis_tdata, DEST_OFF),     lane_byte(s_axis_tdata, DEST_OFF + 1),
                            lane_byte(s_axis_tdata, DEST_OFF + 2), lane_byte(s_axis_tdata, DEST_OFF + 3),
                            lane_byte(s_axis_tdata, DEST_OFF + 4), lane_byte(s_axis_tdata, DEST_OFF + 5)};
                src_p1[47:32] <= {lane_byte(s_axis_tdata, SRC_OFF), lane_byte(s_axis_tdata, SRC_OFF + 1)};
            end
            if (s_acc && state == ST_HDR1) begin
                src_p1[31:0] <= {lane_byte(s_axis_tdata, SRC_OFF + 2 - LANES),
                                 lane_byte(s_axis_tdata, SRC_OFF + 3 - LANES),
                                 lane_byte(s_axis_tdata, SRC_OFF + 4 - LANES),
                                 lane_byte(s_axis_tdata, SRC_OFF + 5 - LANES)};
                type_p1 <= {lane_byte(s_axis_tdata, TYPE_OFF - LANES),
                            lane_byte(s_axis_tdata, TYPE_OFF + 1 - LANES)};
            end
            if (vld_p1 && m_eth_payload_axis_tready) vld_p1 <= 1'b0;
            if (pay_load) begin
                vld_p1      <= 1'b1;
                pay_data_p1 <= rl_data;
                pay_keep_p1 <= rl_keep;
                pay_last_p1 <= rl_last;
                pay_user_p1 <= s_axis_tuser;
            end else if (flush_load) begin
                vld_p1      <= 1'b1;
                pay_data_p1 <= rl_flush_data;
                pay_keep_p1 <= rl_flush_keep;
                pay_last_p1 <= 1'b1;
                pay_user_p1 <= rl_flush_user;
            end
        end
    end

    assign m_eth_hdr_valid                = hdr_vld_p1;
    assign m_eth_dest_mac                 = dest_p1;
    assign m_eth_src_mac                  = src_p1;
    assign m_eth_type                     = type_p1;
    assign m_eth_payload_axis_tdata       = pay_data_p1;
    assign m_eth_payload_axis_tkeep       = pay_keep_p1;
    assign m_eth_payload_axis_tvalid      = vld_p1;
    assign m_eth_payload_axis_tlast       = pay_last_p1;
    assign m_eth_payload_axis_tuser       = pay_user_p1;
    assign error_header_early_termination = err_p1;
    assign busy                           = (state != ST_IDLE) || vld_p1;

endmodule
